// File: rtl/rx_frame_filter_ctrl.sv
// Per-frame accept/drop filter between rx_mac_top and the packet buffer. Writes lag input by 1 cycle; commit/drop land 2 cycles after valid falls.
// Backpressure: wr_full_i gates the pending write and aborts the frame to DISCARD; there is no upstream stall.
module rx_frame_filter_ctrl #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_data_valid_i,
  input  logic             is_preamble_or_sfd_i,
  input  logic             is_dst_mac_i,
  input  logic             is_src_mac_i,
  input  logic             is_ether_type_i,
  input  logic             is_payload_or_crc_i,
  input  logic             invalid_frame_i,
  input  logic [47:0]      station_mac_i,
  input  logic             promisc_en_i,
  input  logic             bcast_en_i,
  input  logic             mcast_en_i,
  input  logic             wr_full_i,
  output logic [7:0]       wr_data_o,
  output logic             wr_en_o,
  output logic             commit_o,
  output logic             drop_o,
  output logic [15:0]      frame_len_o,
  output logic [15:0]      ether_type_o,
  output logic [CNT_W-1:0] frames_ok_o,
  output logic [CNT_W-1:0] frames_drop_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_HDR, S_PAY, S_CLOSE, S_DISCARD
  } state_t;

  localparam logic [15:0] MIN_L = 16'(MIN_FRAME_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_FRAME_LEN);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_inc;
  logic [47:0] dst_q, station_q;
  logic [15:0] type_q;
  logic        err_q, promisc_q, bcast_q, mcast_q;
  logic        wr_en_q;
  logic [7:0]  wr_dat_q;
  logic        field_byte, sfd_byte, in_body, in_frame, write_ok;
  logic        len_over, ovf, abort;
  logic        all_ff, dst_match, accept, commit_d, drop_d;

  assign field_byte = rx_data_valid_i &
                      (is_dst_mac_i | is_src_mac_i | is_ether_type_i | is_payload_or_crc_i);
  assign sfd_byte   = rx_data_valid_i & is_preamble_or_sfd_i;
  assign in_body    = (state_q == S_HDR) || (state_q == S_PAY);
  // The first dst byte arrives while still in PRE, so it must be writable there.
  assign in_frame   = in_body || (state_q == S_PRE);
  assign write_ok   = field_byte & in_frame;
  assign len_inc    = (write_ok && (len_q != 16'hFFFF)) ? len_q + 16'd1 : len_q;
  assign len_over   = write_ok & (len_q >= MAX_L);
  // A full buffer is judged against the strobe actually being presented this cycle.
  assign ovf        = wr_en_q & wr_full_i;
  assign abort      = in_body & (invalid_frame_i | ovf | len_over);

  assign all_ff    = &dst_q;
  assign dst_match = promisc_q | (bcast_q & all_ff) | (mcast_q & dst_q[40] & ~all_ff) |
                     (dst_q == station_q);
  assign accept    = dst_match & (len_q >= MIN_L) & (len_q <= MAX_L) & ~err_q;

  assign wr_en_o   = wr_en_q & ~wr_full_i;
  assign wr_data_o = wr_dat_q;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    commit_d = 1'b0;
    drop_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sfd_byte) state_d = S_PRE;
      end
      S_PRE: begin
        if (!rx_data_valid_i)  state_d = S_IDLE;
        else if (is_dst_mac_i) state_d = S_HDR;
      end
      S_HDR: begin
        if (abort) begin
          state_d = S_DISCARD;
          drop_d  = 1'b1;
        end else if (!rx_data_valid_i) begin
          state_d = S_CLOSE;
        end else if (is_payload_or_crc_i) begin
          state_d = S_PAY;
        end
      end
      S_PAY: begin
        if (abort) begin
          state_d = S_DISCARD;
          drop_d  = 1'b1;
        end else if (!rx_data_valid_i) begin
          state_d = S_CLOSE;
        end
      end
      S_CLOSE: begin
        state_d  = S_IDLE;
        commit_d = accept;
        drop_d   = ~accept;
      end
      S_DISCARD: begin
        if (!rx_data_valid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_en_q       <= 1'b0;
      wr_dat_q      <= '0;
      len_q         <= '0;
      dst_q         <= '0;
      type_q        <= '0;
      err_q         <= 1'b0;
      station_q     <= '0;
      promisc_q     <= 1'b0;
      bcast_q       <= 1'b0;
      mcast_q       <= 1'b0;
      commit_o      <= 1'b0;
      drop_o        <= 1'b0;
      frame_len_o   <= '0;
      ether_type_o  <= '0;
      frames_ok_o   <= '0;
      frames_drop_o <= '0;
    end else begin
      wr_en_q <= write_ok & ~abort;
      if (write_ok) wr_dat_q <= rx_data_i;

      // Every preamble byte re-samples; the SFD is the last one, so its sample wins.
      if (sfd_byte && (state_q == S_IDLE || state_q == S_PRE)) begin
        len_q     <= '0;
        dst_q     <= '0;
        type_q    <= '0;
        err_q     <= 1'b0;
        station_q <= station_mac_i;
        promisc_q <= promisc_en_i;
        bcast_q   <= bcast_en_i;
        mcast_q   <= mcast_en_i;
      end else begin
        len_q <= len_inc;
        if (write_ok && is_dst_mac_i)    dst_q  <= {dst_q[39:0], rx_data_i};
        if (write_ok && is_ether_type_i) type_q <= {type_q[7:0], rx_data_i};
        if (in_frame && invalid_frame_i) err_q  <= 1'b1;
      end

      commit_o <= commit_d;
      drop_o   <= drop_d;
      if (commit_d || drop_d) begin
        frame_len_o  <= len_inc;
        ether_type_o <= type_q;
      end
      if (commit_d) frames_ok_o   <= frames_ok_o + CNT_W'(1);
      if (drop_d)   frames_drop_o <= frames_drop_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rx_frame_filter_ctrl.sv
// Directed and random frames through rx_frame_filter_ctrl; expectations come from
// a frame-level model (match rules, length limits, abort byte position).
module tb_rx_frame_filter_ctrl;

  localparam int MIN_L = 64;
  localparam int MAX_L = 1518;
  localparam int GAP   = 10;
  localparam logic [47:0] STATION = 48'h00_11_22_33_44_55;
  localparam logic [47:0] BCAST   = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MCAST   = 48'h01_00_5E_00_00_01;
  localparam logic [47:0] MISS    = 48'h02_00_00_00_00_01;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid, f_pre, f_dst, f_src, f_type, f_pay, invalid;
  logic [47:0] station;
  logic        promisc, bcast, mcast, wr_full;
  logic [7:0]  wr_data_o;
  logic        wr_en_o, commit_o, drop_o;
  logic [15:0] frame_len_o, ether_type_o;
  logic [31:0] frames_ok_o, frames_drop_o;

  rx_frame_filter_ctrl #(.MIN_FRAME_LEN(MIN_L), .MAX_FRAME_LEN(MAX_L), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .rx_data_i(rx_data), .rx_data_valid_i(rx_valid),
    .is_preamble_or_sfd_i(f_pre), .is_dst_mac_i(f_dst), .is_src_mac_i(f_src),
    .is_ether_type_i(f_type), .is_payload_or_crc_i(f_pay),
    .invalid_frame_i(invalid), .station_mac_i(station),
    .promisc_en_i(promisc), .bcast_en_i(bcast), .mcast_en_i(mcast),
    .wr_full_i(wr_full),
    .wr_data_o(wr_data_o), .wr_en_o(wr_en_o), .commit_o(commit_o), .drop_o(drop_o),
    .frame_len_o(frame_len_o), .ether_type_o(ether_type_o),
    .frames_ok_o(frames_ok_o), .frames_drop_o(frames_drop_o)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  int unsigned model_ok = 0, model_drop = 0;
  int unsigned mon_commit = 0, mon_drop = 0, mon_both = 0;
  logic [7:0]  obs_q[$];
  logic [7:0]  frame_q[$];
  logic [15:0] last_len = '0, last_type = '0;

  always @(negedge clk) begin
    if (wr_en_o) obs_q.push_back(wr_data_o);
    if (commit_o) begin
      mon_commit++;
      last_len  = frame_len_o;
      last_type = ether_type_o;
    end
    if (drop_o) begin
      mon_drop++;
      last_len = frame_len_o;
    end
    if (commit_o && drop_o) mon_both++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    rx_valid = 1'b0; rx_data = '0; invalid = 1'b0; wr_full = 1'b0;
    {f_pre, f_dst, f_src, f_type, f_pay} = '0;
  endtask

  task automatic send_frame(input logic [47:0] dst, input logic [15:0] etype, input int n,
                            input int inv_at, input int full_at, input int rst_at,
                            input bit scramble);
    frame_q.delete();
    for (int i = 0; i < 6; i++) frame_q.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frame_q.push_back(8'($urandom));
    frame_q.push_back(etype[15:8]);
    frame_q.push_back(etype[7:0]);
    while (frame_q.size() < n) frame_q.push_back(8'($urandom));
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b1; f_pre = 1'b1;
      rx_data  = (i == 7) ? 8'hD5 : 8'h55;
    end
    for (int c = 1; c <= n + GAP; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      rst     = !(rst_at > 0 && c == rst_at);
      invalid = (inv_at > 0 && c == inv_at);
      wr_full = (full_at > 0 && c == full_at + 1);
      if (scramble && c == 10) begin
        promisc = ~promisc; bcast = ~bcast; mcast = ~mcast; station = ~station;
      end
      if (c <= n) begin
        rx_valid = 1'b1;
        rx_data  = frame_q[c-1];
        if (c <= 6)       f_dst  = 1'b1;
        else if (c <= 12) f_src  = 1'b1;
        else if (c <= 14) f_type = 1'b1;
        else              f_pay  = 1'b1;
      end
    end
  endtask

  task automatic run_frame(input string tag, input logic [47:0] dst, input logic [15:0] etype,
                           input int n, input int inv_at, input int full_at, input int rst_at,
                           input bit scramble);
    int unsigned c0, d0, b0;
    int          o0, wr, mism, got_wr;
    logic        p, b, m;
    logic [47:0] st;
    bit          bc, mc, match, aborted, exp_commit, exp_drop;
    c0 = mon_commit; d0 = mon_drop; b0 = mon_both; o0 = obs_q.size();
    p = promisc; b = bcast; m = mcast; st = station;
    send_frame(dst, etype, n, inv_at, full_at, rst_at, scramble);
    promisc = p; bcast = b; mcast = m; station = st;
    @(negedge clk);

    // Frame-level expectations: config as seen at SFD, writes stop before the abort byte.
    bc    = (dst == BCAST);
    mc    = dst[40] && !bc;
    match = p || (b && bc) || (m && mc) || (dst == st);
    wr    = (n > MAX_L) ? MAX_L : n;
    if (inv_at  > 0 && inv_at  - 1 < wr) wr = inv_at - 1;
    if (full_at > 0 && full_at - 1 < wr) wr = full_at - 1;
    if (rst_at  > 0 && rst_at  - 1 < wr) wr = rst_at - 1;
    aborted    = (n > MAX_L) || inv_at > 0 || full_at > 0;
    exp_commit = 1'b0;
    exp_drop   = 1'b0;
    if (rst_at > 0) begin
      model_ok   = 0;
      model_drop = 0;
    end else if (!aborted && match && n >= MIN_L) begin
      exp_commit = 1'b1;
    end else begin
      exp_drop = 1'b1;
    end
    if (exp_commit) model_ok++;
    if (exp_drop)   model_drop++;

    got_wr = obs_q.size() - o0;
    check_eq({tag, "/writes"}, got_wr, wr);
    mism = 0;
    for (int i = 0; i < got_wr && i < wr; i++)
      if (obs_q[o0+i] !== frame_q[i]) mism++;
    check_eq({tag, "/data"}, mism, 0);
    check_eq({tag, "/commits"}, mon_commit - c0, exp_commit);
    check_eq({tag, "/drops"}, mon_drop - d0, exp_drop);
    check_eq({tag, "/both"}, mon_both - b0, 0);
    if (exp_commit) begin
      check_eq({tag, "/etype"}, last_type, etype);
      check_eq({tag, "/len"}, last_len, n);
    end else if (exp_drop && inv_at == 0 && full_at == 0) begin
      check_eq({tag, "/len"}, last_len, (n > MAX_L) ? MAX_L + 1 : n);
    end
    if (rst_at > 0) check_eq({tag, "/len_rst"}, frame_len_o, 0);
    check_eq({tag, "/ok_cnt"}, frames_ok_o, model_ok);
    check_eq({tag, "/drop_cnt"}, frames_drop_o, model_drop);
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    station = STATION; promisc = 1'b0; bcast = 1'b0; mcast = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst/wr_en", wr_en_o, 0);
    check_eq("rst/pulses", {commit_o, drop_o}, 0);
    check_eq("rst/len", frame_len_o, 0);
    check_eq("rst/etype", ether_type_o, 0);
    check_eq("rst/ok_cnt", frames_ok_o, 0);
    check_eq("rst/drop_cnt", frames_drop_o, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_frame("t1_unicast", STATION, 16'h0800, 64, 0, 0, 0, 1'b0);
    run_frame("t2_miss", MISS, 16'h0800, 64, 0, 0, 0, 1'b0);
    promisc = 1'b1;
    run_frame("t2_promisc", MISS, 16'h0800, 64, 0, 0, 0, 1'b0);
    promisc = 1'b0;
    run_frame("t3_bcast_off", BCAST, 16'h0806, 64, 0, 0, 0, 1'b0);
    bcast = 1'b1;
    run_frame("t3_bcast_on", BCAST, 16'h0806, 64, 0, 0, 0, 1'b0);
    bcast = 1'b0; mcast = 1'b1;
    run_frame("t3_mcast", MCAST, 16'h0800, 80, 0, 0, 0, 1'b0);
    mcast = 1'b0;
    run_frame("t4_runt", STATION, 16'h86DD, 60, 0, 0, 0, 1'b0);
    run_frame("t4_max", STATION, 16'h88CC, MAX_L, 0, 0, 0, 1'b0);
    run_frame("t4_long", STATION, 16'h88CC, MAX_L + 1, 0, 0, 0, 1'b0);
    run_frame("t5_invalid", STATION, 16'h0800, 128, 30, 0, 0, 1'b0);
    run_frame("t5_full", STATION, 16'h0800, 128, 0, 100, 0, 1'b0);
    run_frame("t5_inv_last", STATION, 16'h0800, 64, 64, 0, 0, 1'b0);
    run_frame("t6_reset", STATION, 16'h0800, 64, 0, 0, 20, 1'b0);
    run_frame("t6_after", STATION, 16'h0800, 64, 0, 0, 0, 1'b0);
    run_frame("cfg_mid", MISS, 16'h0800, 64, 0, 0, 0, 1'b1);

    for (int k = 0; k < 40; k++) begin
      logic [47:0] d;
      int          n, ia, fa, sel, ev;
      sel = $urandom_range(0, 4);
      case (sel)
        0:       d = STATION;
        1:       d = BCAST;
        2:       d = MCAST;
        3:       d = MISS;
        default: d = {16'($urandom), 32'($urandom)};
      endcase
      promisc = 1'($urandom_range(0, 1));
      bcast   = 1'($urandom_range(0, 1));
      mcast   = 1'($urandom_range(0, 1));
      n  = ($urandom_range(0, 9) == 0) ? $urandom_range(1510, 1525) : $urandom_range(14, 130);
      ev = $urandom_range(0, 5);
      ia = 0;
      fa = 0;
      if (ev == 0)      ia = $urandom_range(2, n);
      else if (ev == 1) fa = $urandom_range(1, n);
      run_frame("rand", d, 16'($urandom), n, ia, fa, 0, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
